ctrl_rd_requester: RTL and testbench

- Read-request initiator that polls the host control word. It owns the c0 read path for control reads, so ctrl_resp_if becomes a pure decoder.
- Issues one control-line read (mdata = READ_CTRL_MDATA) and steers the matching c0 response into ctrl_resp_if as ctrl_resp_valid.
- Re-polls after a programmable backoff whenever ctrl_resp_if reports a stale nonce (ack without valid).
- Sits beside the top AFU FSM; active while the AFU is in AFU_CTRL.

---
 rtl/ctrl_rd_requester_pkg.sv | 27 ++
 rtl/ctrl_rd_requester_poll_backoff.sv | 38 +++
 rtl/ctrl_rd_requester.sv | 165 ++++++++++++++++
 tb/tb_ctrl_rd_requester.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_rd_requester_pkg.sv
// ctrl_rd_requester_pkg
//   Shared definitions for the control-word read requester: the c0 mdata tag
//   used for control-line reads, the default re-poll backoff, the requester
//   state type, and a saturating counter helper for the optional statistics.
package ctrl_rd_requester_pkg;

  // mdata tag carried by control-line reads; responses are matched on it.
  localparam logic [15:0] READ_CTRL_MDATA = 16'd3;

  localparam int DEFAULT_POLL_INTERVAL = 64;
  localparam int DEFAULT_ADDR_W        = 42;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RESP = 3'd2,
    WAIT_ACK  = 3'd3,
    BACKOFF   = 3'd4,
    GOT       = 3'd5
  } e_ctrl_rd_state;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ctrl_rd_requester_poll_backoff.sv
// ctrl_poll_backoff
//   Loadable down-counter that times the gap between a stale control word
//   and the next poll. load presets the count to POLL_INTERVAL-1; dec
//   counts down and stops at zero; done is high whenever the count is zero.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-low reset (count cleared to 0)
//   load   in   preset count to POLL_INTERVAL-1 (wins over dec)
//   dec    in   count down by one, holding at zero
//   done   out  count is zero
module ctrl_poll_backoff #(
  parameter int POLL_INTERVAL = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(POLL_INTERVAL - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/ctrl_rd_requester.sv
// ctrl_rd_requester
//   Polls the host control word over the c0 read channel. Issues a single
//   control-line read, steers the matching response to the control decoder
//   as ctrl_resp_valid, and re-polls after POLL_INTERVAL cycles whenever the
//   decoder reports a stale nonce. Only one control read is ever in flight.
//
//   Optional build macro CTRL_RD_REQUESTER_STATS_EN adds saturating
//   poll_count / stale_count outputs and a message on every stale ack.
//
// Ports:
//   clk              in   AFU clock
//   reset            in   synchronous active-low reset
//   enable           in   poll while high
//   ctrl_addr        in   cache-line address of the control word
//   c0_alm_full      in   c0 TX almost-full
//   rd_req_valid     out  c0 read request strobe (registered, one cycle)
//   rd_req_addr      out  request address (zero when no request)
//   rd_req_mdata     out  request mdata (zero when no request)
//   rx_rd_valid      in   c0 RX read response valid
//   rx_rd_mdata      in   c0 RX response mdata
//   ctrl_resp_valid  out  matching response for the decoder (combinational)
//   ctrl_ack         in   decoder ack
//   ctrl_valid       in   decoder says the word carried a fresh nonce
//   ctrl_got         out  fresh control word accepted (level)
//   busy             out  poll in progress (not IDLE, not GOT)
//   poll_count       out  [stats build] requests issued
//   stale_count      out  [stats build] stale acks seen
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | not polling; wait for enable
// ISSUE      | request pending, waiting for c0 TX space
// WAIT_RESP  | request in flight, waiting for the READ_CTRL_MDATA response
// WAIT_ACK   | response handed to the decoder, waiting for its verdict
// BACKOFF    | stale nonce seen, counting down to the next poll
// GOT        | fresh word accepted; hold until enable falls
module ctrl_rd_requester
  import ctrl_rd_requester_pkg::*;
#(
  parameter int POLL_INTERVAL = DEFAULT_POLL_INTERVAL,
  parameter int ADDR_W        = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic              c0_alm_full,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [15:0]       rd_req_mdata,
  input  logic              rx_rd_valid,
  input  logic [15:0]       rx_rd_mdata,
  output logic              ctrl_resp_valid,
  input  logic              ctrl_ack,
  input  logic              ctrl_valid,
  output logic              ctrl_got,
`ifdef CTRL_RD_REQUESTER_STATS_EN
  output logic [31:0]       poll_count,
  output logic [31:0]       stale_count,
`endif
  output logic              busy
);

  e_ctrl_rd_state state;
  e_ctrl_rd_state state_next;

  logic resp_match;
  logic issue;
  logic stale_ack;
  logic backoff_done;

  assign resp_match = rx_rd_valid && (rx_rd_mdata == READ_CTRL_MDATA);

  ctrl_poll_backoff #(
    .POLL_INTERVAL(POLL_INTERVAL)
  ) u_backoff (
    .clk   (clk),
    .reset (reset),
    .load  (stale_ack),
    .dec   (state == BACKOFF),
    .done  (backoff_done)
  );

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    stale_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = ISSUE;
      end
      ISSUE: begin
        // Disable beats issuing; almost-full sampled this cycle suppresses it.
        if (!enable) begin
          state_next = IDLE;
        end else if (!c0_alm_full) begin
          issue      = 1'b1;
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A response arriving after disable is drained without reaching the
        // decoder so its nonce is left unconsumed.
        if (resp_match) state_next = enable ? WAIT_ACK : IDLE;
      end
      WAIT_ACK: begin
        if (ctrl_ack) begin
          if (ctrl_valid) begin
            state_next = GOT;
          end else begin
            stale_ack  = 1'b1;
            state_next = BACKOFF;
          end
        end
      end
      BACKOFF: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (backoff_done) begin
          state_next = ISSUE;
        end
      end
      GOT: begin
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
    end else begin
      state        <= state_next;
      rd_req_valid <= issue;
      rd_req_addr  <= issue ? ctrl_addr : '0;
      rd_req_mdata <= issue ? READ_CTRL_MDATA : 16'd0;
    end
  end

  // Gated by reset so nothing reaches the decoder in a reset cycle.
  assign ctrl_resp_valid = reset && (state == WAIT_RESP) && resp_match && enable;
  assign ctrl_got        = (state == GOT);
  assign busy            = (state != IDLE) && (state != GOT);

`ifdef CTRL_RD_REQUESTER_STATS_EN
  // poll_count advances on the same edge that raises rd_req_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      poll_count  <= '0;
      stale_count <= '0;
    end else begin
      if (issue) poll_count <= sat_inc32(poll_count);
      if (stale_ack) begin
        stale_count <= sat_inc32(stale_count);
        $display("[RD REQ] - stale control word, re-polling");
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_rd_requester.sv
module tb_ctrl_rd_requester;

  localparam int P  = 4;
  localparam int AW = 42;

  // Model phases, named after what the host sees rather than DUT states.
  localparam int M_OFF      = 0;
  localparam int M_ARMED    = 1;
  localparam int M_INFLIGHT = 2;
  localparam int M_DECODE   = 3;
  localparam int M_HOLDOFF  = 4;
  localparam int M_DONE     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, c0_alm_full, rx_rd_valid, ctrl_ack, ctrl_valid;
  logic [AW-1:0] ctrl_addr;
  logic [15:0]   rx_rd_mdata;
  logic          rd_req_valid, ctrl_resp_valid, ctrl_got, busy;
  logic [AW-1:0] rd_req_addr;
  logic [15:0]   rd_req_mdata;
`ifdef CTRL_RD_REQUESTER_STATS_EN
  logic [31:0]   poll_count, stale_count;
`endif

  ctrl_rd_requester #(.POLL_INTERVAL(P), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .ctrl_addr       (ctrl_addr),
    .c0_alm_full     (c0_alm_full),
    .rd_req_valid    (rd_req_valid),
    .rd_req_addr     (rd_req_addr),
    .rd_req_mdata    (rd_req_mdata),
    .rx_rd_valid     (rx_rd_valid),
    .rx_rd_mdata     (rx_rd_mdata),
    .ctrl_resp_valid (ctrl_resp_valid),
    .ctrl_ack        (ctrl_ack),
    .ctrl_valid      (ctrl_valid),
    .ctrl_got        (ctrl_got),
`ifdef CTRL_RD_REQUESTER_STATS_EN
    .poll_count      (poll_count),
    .stale_count     (stale_count),
`endif
    .busy            (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Shadow inputs, copied onto the DUT pins at each falling edge.
  logic          t_rst = 1'b0, t_en = 1'b0, t_af = 1'b0;
  logic          t_rxv = 1'b0, t_ack = 1'b0, t_vld = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [15:0]   t_rxm = '0;

  int            m_mode = M_OFF;
  int            m_resume = 0;
  logic          m_req = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int unsigned   m_polls = 0, m_stales = 0;
  int            cyc = 0;

  int            dut_reqs = 0, dut_resps = 0, last_req_step = 0;
  logic [AW-1:0] last_req_addr = '0;
  logic [15:0]   last_req_mdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic quiet();
    t_rxv = 1'b0; t_rxm = 16'd0; t_ack = 1'b0; t_vld = 1'b0;
  endtask

  // One clock: apply inputs, compare against the model, advance the model.
  task automatic step();
    logic match, exp_resp;
    @(negedge clk);
    reset = t_rst; enable = t_en; ctrl_addr = t_addr; c0_alm_full = t_af;
    rx_rd_valid = t_rxv; rx_rd_mdata = t_rxm; ctrl_ack = t_ack; ctrl_valid = t_vld;
    #1;
    match    = t_rxv && (t_rxm == 16'd3);
    exp_resp = t_rst && (m_mode == M_INFLIGHT) && match && t_en;
    chk("rd_req_valid", rd_req_valid, m_req);
    if (m_req) begin
      chk("rd_req_addr", rd_req_addr, m_addr);
      chk("rd_req_mdata", rd_req_mdata, 16'd3);
    end
    chk("ctrl_resp_valid", ctrl_resp_valid, exp_resp);
    chk("ctrl_got", ctrl_got, m_mode == M_DONE);
    chk("busy", busy, !(m_mode == M_OFF || m_mode == M_DONE));
`ifdef CTRL_RD_REQUESTER_STATS_EN
    chk("poll_count", poll_count, m_polls);
    chk("stale_count", stale_count, m_stales);
`endif
    if (rd_req_valid === 1'b1) begin
      dut_reqs++; last_req_step = cyc;
      last_req_addr = rd_req_addr; last_req_mdata = rd_req_mdata;
    end
    if (ctrl_resp_valid === 1'b1) dut_resps++;

    if (!t_rst) begin
      m_mode = M_OFF; m_req = 1'b0; m_addr = '0; m_polls = 0; m_stales = 0;
    end else begin
      m_req = 1'b0;
      case (m_mode)
        M_OFF:      if (t_en) m_mode = M_ARMED;
        M_ARMED: begin
          if (!t_en) m_mode = M_OFF;
          else if (!t_af) begin
            m_req = 1'b1; m_addr = t_addr; m_polls++; m_mode = M_INFLIGHT;
          end
        end
        M_INFLIGHT: if (match) m_mode = t_en ? M_DECODE : M_OFF;
        M_DECODE: begin
          if (t_ack) begin
            if (t_vld) m_mode = M_DONE;
            else begin
              // Next request may enter ISSUE P cycles after the stale ack.
              m_mode = M_HOLDOFF; m_resume = cyc + P; m_stales++;
            end
          end
        end
        M_HOLDOFF: begin
          if (!t_en) m_mode = M_OFF;
          else if (cyc >= m_resume) m_mode = M_ARMED;
        end
        M_DONE:     if (!t_en) m_mode = M_OFF;
        default:    m_mode = M_OFF;
      endcase
    end
    cyc++;
  endtask

  task automatic wait_req(input int max, input string name);
    int start;
    start = dut_reqs;
    for (int i = 0; i < max && dut_reqs == start; i++) step();
    chk({name, "_req_seen"}, (dut_reqs != start), 1'b1);
  endtask

  task automatic respond(input logic fresh);
    t_rxv = 1'b1; t_rxm = 16'd3;
    step();
    quiet();
    t_ack = 1'b1; t_vld = fresh;
    step();
    quiet();
  endtask

  task automatic do_reset();
    quiet();
    t_en = 1'b0; t_af = 1'b0; t_rst = 1'b0;
    step();
    t_rst = 1'b1;
    step();
    dut_reqs = 0; dut_resps = 0;
  endtask

  int stale_step, clear_step, rel_step;

  initial begin
    reset = 1'b0; enable = 1'b0; ctrl_addr = '0; c0_alm_full = 1'b0;
    rx_rd_valid = 1'b0; rx_rd_mdata = '0; ctrl_ack = 1'b0; ctrl_valid = 1'b0;
    repeat (2) @(posedge clk);
    step();
    chk("reset_req_valid", rd_req_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_got", ctrl_got, 1'b0);

    // Fresh word on the first poll.
    do_reset();
    t_en = 1'b1; t_addr = AW'(42'h1000);
    wait_req(5, "s1");
    chk("s1_addr", last_req_addr, 42'h1000);
    chk("s1_mdata", last_req_mdata, 16'd3);
    repeat (9) step();
    respond(1'b1);
    repeat (2) step();
    chk("s1_reqs", dut_reqs, 1);
    chk("s1_resps", dut_resps, 1);
    chk("s1_got", ctrl_got, 1'b1);
    chk("s1_busy", busy, 1'b0);

    // Stale then fresh: re-poll spacing.
    do_reset();
    t_en = 1'b1;
    wait_req(5, "s2a");
    repeat (3) step();
    t_rxv = 1'b1; t_rxm = 16'd3;
    step();
    quiet();
    t_ack = 1'b1; t_vld = 1'b0; stale_step = cyc;
    step();
    quiet();
    wait_req(20, "s2b");
    // Request register rises P+1 edges after the ack edge; observed one step later.
    chk("s2_gap", last_req_step - stale_step, 6);
    respond(1'b1);
    repeat (2) step();
    chk("s2_reqs", dut_reqs, 2);
    chk("s2_got", ctrl_got, 1'b1);
`ifdef CTRL_RD_REQUESTER_STATS_EN
    chk("s2_poll_count", poll_count, 2);
    chk("s2_stale_count", stale_count, 1);
`endif

    // Backpressure.
    do_reset();
    t_af = 1'b1; t_en = 1'b1;
    repeat (20) step();
    chk("s3_no_req", dut_reqs, 0);
    chk("s3_busy", busy, 1'b1);
    t_af = 1'b0; clear_step = cyc;
    wait_req(5, "s3");
    chk("s3_gap", last_req_step - clear_step, 1);
    repeat (3) step();
    chk("s3_reqs", dut_reqs, 1);
    respond(1'b1);

    // Foreign mdata ignored.
    do_reset();
    t_en = 1'b1;
    wait_req(5, "s4");
    repeat (2) step();
    t_rxv = 1'b1; t_rxm = 16'd5;
    step();
    quiet();
    chk("s4_foreign_resp", dut_resps, 0);
    chk("s4_busy", busy, 1'b1);
    repeat (2) step();
    t_rxv = 1'b1; t_rxm = 16'd3;
    step();
    quiet();
    chk("s4_match_resp", dut_resps, 1);
    t_ack = 1'b1; t_vld = 1'b1;
    step();
    quiet();

    // Disable while the read is in flight.
    do_reset();
    t_en = 1'b1;
    wait_req(5, "s5");
    t_en = 1'b0;
    repeat (2) step();
    t_rxv = 1'b1; t_rxm = 16'd3;
    step();
    quiet();
    chk("s5_drain_resp", dut_resps, 0);
    repeat (2) step();
    chk("s5_busy", busy, 1'b0);
    repeat (10) step();
    chk("s5_reqs", dut_reqs, 1);

    // Reset in the middle of backoff.
    do_reset();
    t_en = 1'b1;
    wait_req(5, "s6a");
    repeat (2) step();
    respond(1'b0);
    repeat (2) step();
    chk("s6_busy_backoff", busy, 1'b1);
    t_rst = 1'b0;
    step();
    t_rst = 1'b1;
    @(posedge clk); #1;
    chk("s6_rst_req", rd_req_valid, 1'b0);
    chk("s6_rst_busy", busy, 1'b0);
    chk("s6_rst_got", ctrl_got, 1'b0);
    rel_step = cyc;
    dut_reqs = 0;
    wait_req(6, "s6b");
    chk("s6_gap", last_req_step - rel_step, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      quiet();
      t_rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) t_en = !t_en;
      t_af   = ($urandom_range(0, 3) == 0);
      t_addr = AW'({$urandom, $urandom});
      if (m_mode == M_INFLIGHT && $urandom_range(0, 5) == 0) begin
        t_rxv = 1'b1; t_rxm = 16'd3;
      end else if ($urandom_range(0, 9) == 0) begin
        t_rxv = 1'b1; t_rxm = 16'($urandom_range(4, 65535));
      end
      if (m_mode == M_DECODE && $urandom_range(0, 2) != 0) begin
        t_ack = 1'b1; t_vld = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
